cpu_mem_loader: RTL and testbench
=================================

Name: cpu_mem_loader

Overview:
Host-side initiator for the CPU's external memory-access ports (instruction-memory and data-memory `*_ext` / `*_ext_2` ports) and for its `enable` input.
- Accepts word-level commands over a valid/ready interface: load program, load data, read back memory, run.
- Sequences the SRAM ext-port handshakes and returns one response per command.
- Sits between the testbench/host link and the cpu top-level.

Parameters:
- RD_LAT, 1, SRAM ext-port read latency in cycles from the ren_ext edge to valid rdata_ext (1..4).
- RUN_CNT_W, 32, width of the run-cycle counter.

Ports:
- clk  in  1  main clock
- arst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  0=WR_IMEM, 1=WR_DMEM, 2=RD_MEM (cmd_data[0] selects: 0=IMEM, 1=DMEM), 3=RUN
- cmd_addr  in  32  byte address for WR/RD
- cmd_data  in  32  write word, RD memory select, or RUN cycle count
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_err  out  1  1 = command failed
- rsp_data  out  32  read word (RD), cycles executed (RUN), else 0
- cpu_enable  out  1  to cpu enable
- addr_ext, wdata_ext  out  32  IMEM ext address / write data
- wen_ext, ren_ext  out  1  IMEM ext write / read enables
- rdata_ext  in  32  IMEM ext read data
- addr_ext_2, wdata_ext_2  out  32  DMEM ext address / write data
- wen_ext_2, ren_ext_2  out  1  DMEM ext write / read enables
- rdata_ext_2  in  32  DMEM ext read data

Behaviour:
- Reset: all outputs 0, state IDLE; cmd_ready rises in the first cycle after reset release.
- Reset mid-operation aborts the command: no response, enables drop at the next edge.
- States: IDLE, WRITE, RD_WAIT, RUN, RESP.
- Command handshake: a command is accepted on a cycle with cmd_valid && cmd_ready. cmd_ready=1 only in IDLE, so one command is in flight at a time.
- Alignment check: cmd_addr[1:0]!=0 for WR/RD -> no memory access; go to RESP with rsp_err=1.
- WRITE: exactly one cycle with the selected wen=1 and addr/wdata driven from the registered command, then RESP.
  - Write-to-accept-edge latency: 1 cycle.
- RD_MEM: selected ren=1 for exactly one cycle, then RD_WAIT counts RD_LAT-1 more cycles.
  - rdata is captured in the RD_LAT-th cycle after the ren cycle, then RESP.
- Exclusivity:
  - Never assert wen and ren on the same port in the same cycle.
  - Never touch both ports in one cycle.
  - All ext enables are 0 whenever cpu_enable=1.
- RUN: cpu_enable=1 for exactly cmd_data consecutive cycles, then 0; then RESP with rsp_data=cmd_data.
  - cmd_data=0: cpu_enable never asserts; RESP on the next cycle.
  - Counter is RUN_CNT_W bits, counts down, no wrap (stops at 0).
- RESP: rsp_valid=1 with rsp_err and rsp_data held stable until rsp_ready.
  - Transfer edge -> IDLE; cmd_ready=1 the following cycle.
  - rsp_valid must not drop before rsp_ready.
- cmd_valid with cmd_ready=0 is ignored; the host holds it.
- Unused ext outputs (addr/wdata) hold their last value; enables are the only qualifiers.

Optional Feature:
- Macro CPU_MEM_LOADER_VERIFY_EN.
- Defined: after each WRITE, the block issues a readback on the same port/address (VERIFY state, RD_LAT wait) and compares with the written word.
  - Mismatch -> rsp_err=1, rsp_data=readback word.
  - Match -> rsp_err=0, rsp_data=0.
  - Write latency to response grows by 1+RD_LAT cycles.
- Undefined: no readback; WRITE responds with rsp_err=0 immediately after the write cycle.

Decomposition:
- Shared package cpu_loader_pkg:
  - cmd_op encodings (OP_WR_IMEM, OP_WR_DMEM, OP_RD_MEM, OP_RUN)
  - state encoding localparams
  - MEMSEL_IMEM/MEMSEL_DMEM
- One natural sub-module: loader_down_counter (load, decrement, zero flag), reused for the RD_LAT wait and the RUN count.

Test Plan:
- WR_IMEM addr=0x8, data=0xDEADBEEF -> one cycle with wen_ext=1, addr_ext=0x8, wdata_ext=0xDEADBEEF; wen_ext_2 stays 0; rsp_err=0.
- WR_DMEM 0x10=0x1234, then RD_MEM addr=0x10, sel=1 with RD_LAT=1 -> ren_ext_2 pulses once; rsp_data=0x00001234, rsp_err=0.
- RUN data=5 -> cpu_enable high exactly 5 cycles with all ext enables 0; rsp_data=5. RUN data=0 -> cpu_enable never high; response the next cycle.
- WR_IMEM addr=0x6 -> no wen pulse; rsp_err=1.
- Response backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_data stable, cmd_ready=0 throughout; accept -> cmd_ready=1 the following cycle.
- Reset low during RUN count=100 at cycle 20 -> cpu_enable=0 after the next edge, no rsp_valid; after release, a new WR command works normally. With VERIFY_EN and a forced-mismatch SRAM model -> rsp_err=1.

Source files
------------

// File: rtl/cpu_loader_pkg.sv
// cpu_loader_pkg: command encodings, memory selects and FSM states for cpu_mem_loader
package cpu_loader_pkg;
  localparam logic [1:0] OP_WR_IMEM = 2'd0;
  localparam logic [1:0] OP_WR_DMEM = 2'd1;
  localparam logic [1:0] OP_RD_MEM  = 2'd2;
  localparam logic [1:0] OP_RUN     = 2'd3;
  localparam logic MEMSEL_IMEM = 1'b0;
  localparam logic MEMSEL_DMEM = 1'b1;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RUN     = 3'd3,
    ST_RESP    = 3'd4,
    ST_VERIFY  = 3'd5
  } state_t;
endpackage

// File: rtl/loader_down_counter.sv
// loader_down_counter: loadable down counter that stops at zero
module loader_down_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);
  assign zero = count == '0;
  always_ff @(posedge clk)
    if (!arst_n) count <= '0;
    else if (load) count <= load_val;
    else if (dec && !zero) count <= count - W'(1);
endmodule

// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader: host command sequencer for the cpu's IMEM/DMEM ext ports and enable
// Optional write readback-verify: define CPU_MEM_LOADER_VERIFY_EN
module cpu_mem_loader
  import cpu_loader_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int RUN_CNT_W = 32
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_err,
  output logic [31:0] rsp_data,
  output logic        cpu_enable,
  output logic [31:0] addr_ext,
  output logic [31:0] wdata_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  input  logic [31:0] rdata_ext,
  output logic [31:0] addr_ext_2,
  output logic [31:0] wdata_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  input  logic [31:0] rdata_ext_2
);
  state_t               state;
  logic                 sel;
  logic                 accept;
  logic                 cmd_sel;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic [RUN_CNT_W-1:0] cnt_val;
  logic [RUN_CNT_W-1:0] cnt;
  logic [31:0]          rd_word;
  assign accept  = cmd_valid && cmd_ready;
  assign cmd_sel = cmd_op == OP_WR_DMEM || (cmd_op == OP_RD_MEM && cmd_data[0]);
  assign rd_word = sel == MEMSEL_DMEM ? rdata_ext_2 : rdata_ext;
  always_comb begin
`ifdef CPU_MEM_LOADER_VERIFY_EN
    cnt_load = accept || state == ST_WRITE;
`else
    cnt_load = accept;
`endif
    cnt_val = accept && cmd_op == OP_RUN ? cmd_data[RUN_CNT_W-1:0] - RUN_CNT_W'(1)
                                         : RUN_CNT_W'(RD_LAT);
    cnt_dec = state == ST_RD_WAIT || state == ST_RUN || state == ST_VERIFY;
  end
  loader_down_counter #(.W(RUN_CNT_W)) u_cnt (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state       <= ST_IDLE;
      sel         <= MEMSEL_IMEM;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
      cpu_enable  <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      wen_ext     <= 1'b0;
      ren_ext     <= 1'b0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
    end else begin
      wen_ext   <= 1'b0;
      ren_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      ren_ext_2 <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= !accept;
          if (accept) begin
            sel      <= cmd_sel;
            rsp_err  <= 1'b0;
            rsp_data <= cmd_op == OP_RUN ? cmd_data : '0;
            if (cmd_op == OP_RUN) begin
              cpu_enable <= cmd_data != '0;
              rsp_valid  <= cmd_data == '0;
              state      <= cmd_data != '0 ? ST_RUN : ST_RESP;
            end else if (cmd_addr[1:0] != 2'b00) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else if (!cmd_op[1]) begin
              if (cmd_sel) begin
                addr_ext_2  <= cmd_addr;
                wdata_ext_2 <= cmd_data;
                wen_ext_2   <= 1'b1;
              end else begin
                addr_ext  <= cmd_addr;
                wdata_ext <= cmd_data;
                wen_ext   <= 1'b1;
              end
              state <= ST_WRITE;
            end else begin
              if (cmd_sel) begin
                addr_ext_2 <= cmd_addr;
                ren_ext_2  <= 1'b1;
              end else begin
                addr_ext <= cmd_addr;
                ren_ext  <= 1'b1;
              end
              state <= ST_RD_WAIT;
            end
          end
        end
        ST_WRITE: begin
`ifdef CPU_MEM_LOADER_VERIFY_EN
          ren_ext_2 <= sel == MEMSEL_DMEM;
          ren_ext   <= sel == MEMSEL_IMEM;
          state     <= ST_VERIFY;
`else
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
`endif
        end
        // the ren cycle plus RD_LAT cycles; rdata is valid in the last one
        ST_RD_WAIT: if (cnt_zero) begin
          rsp_data  <= rd_word;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
`ifdef CPU_MEM_LOADER_VERIFY_EN
        ST_VERIFY: if (cnt_zero) begin
          rsp_err   <= rd_word != (sel == MEMSEL_DMEM ? wdata_ext_2 : wdata_ext);
          rsp_data  <= rd_word != (sel == MEMSEL_DMEM ? wdata_ext_2 : wdata_ext) ? rd_word : '0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
`endif
        ST_RUN: if (cnt_zero) begin
          cpu_enable <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb_cpu_mem_loader: directed self-checking bench for cpu_mem_loader with behavioural SRAMs
module tb_cpu_mem_loader;
  localparam int RD_LAT = 1;
`ifdef CPU_MEM_LOADER_VERIFY_EN
  localparam int WR_LAT = 2 + RD_LAT;
`else
  localparam int WR_LAT = 1;
`endif
  logic        clk = 0;
  logic        arst_n = 0;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 0;
  logic [31:0] cmd_addr = 0;
  logic [31:0] cmd_data = 0;
  logic        rsp_valid;
  logic        rsp_ready = 0;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic        cpu_enable;
  logic [31:0] addr_ext, wdata_ext, rdata_ext;
  logic        wen_ext, ren_ext;
  logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext_2, ren_ext_2;
  logic        corrupt = 0;
  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  int n_chk = 0, n_fail = 0;
  int n_wen = 0, n_ren = 0, n_wen2 = 0, n_ren2 = 0, n_en = 0, n_rv = 0, n_viol = 0;
  logic [31:0] w_addr = 0, w_data = 0;

  cpu_mem_loader #(.RD_LAT(RD_LAT), .RUN_CNT_W(32)) dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wdata_ext(wdata_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wdata_ext_2(wdata_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wen_ext) imem[addr_ext[9:2]] <= wdata_ext;
    if (ren_ext) rdata_ext <= imem[addr_ext[9:2]] ^ {31'b0, corrupt};
    if (wen_ext_2) dmem[addr_ext_2[9:2]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[9:2]] ^ {31'b0, corrupt};
  end

  always @(negedge clk) begin
    if (wen_ext) begin n_wen++; w_addr = addr_ext; w_data = wdata_ext; end
    if (ren_ext) n_ren++;
    if (wen_ext_2) begin n_wen2++; w_addr = addr_ext_2; w_data = wdata_ext_2; end
    if (ren_ext_2) n_ren2++;
    if (cpu_enable) n_en++;
    if (rsp_valid) n_rv++;
    if ((wen_ext && ren_ext) || (wen_ext_2 && ren_ext_2) ||
        ((wen_ext || ren_ext) && (wen_ext_2 || ren_ext_2)) ||
        (cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2))) n_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    int w = 0;
    while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
    if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
    cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic get_rsp(output logic err, output logic [31:0] data, output int waits);
    waits = 0;
    while (!rsp_valid && waits < 300) begin @(negedge clk); waits++; end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
    err = rsp_err; data = rsp_data;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  initial begin
    logic err;
    logic [31:0] d, d0;
    int waits, s0, s1, s2, s3, bad;
    repeat (3) @(negedge clk);
    check("rst_outs", {cmd_ready, rsp_valid, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, rsp_err}, 0);
    check("rst_rsp_data", rsp_data, 0);
    arst_n = 1;
    @(negedge clk);
    check("rdy_after_rst", cmd_ready, 1);

    s0 = n_wen; s1 = n_wen2;
    send(2'd0, 32'h8, 32'hDEADBEEF);
    get_rsp(err, d, waits);
    check("wri_wen", n_wen - s0, 1);
    check("wri_wen2", n_wen2 - s1, 0);
    check("wri_addr", w_addr, 32'h8);
    check("wri_wdata", w_data, 32'hDEADBEEF);
    check("wri_err", err, 0);
    check("wri_data", d, 0);
    check("wri_lat", waits, WR_LAT);
    check("rdy_after_rsp", cmd_ready, 1);

    send(2'd1, 32'h10, 32'h1234);
    get_rsp(err, d, waits);
    check("wrd_err", err, 0);
    s0 = n_ren; s1 = n_ren2;
    send(2'd2, 32'h10, 32'h1);
    get_rsp(err, d, waits);
    check("rdd_ren2", n_ren2 - s1, 1);
    check("rdd_ren", n_ren - s0, 0);
    check("rdd_data", d, 32'h00001234);
    check("rdd_err", err, 0);
    check("rdd_lat", waits, 1 + RD_LAT);
    send(2'd2, 32'h8, 32'h0);
    get_rsp(err, d, waits);
    check("rdi_data", d, 32'hDEADBEEF);

    s0 = n_en; s1 = n_viol;
    send(2'd3, 32'h0, 32'd5);
    get_rsp(err, d, waits);
    check("run5_en", n_en - s0, 5);
    check("run5_data", d, 5);
    check("run5_err", err, 0);
    check("run5_viol", n_viol - s1, 0);
    s0 = n_en;
    send(2'd3, 32'h0, 32'd0);
    get_rsp(err, d, waits);
    check("run0_en", n_en - s0, 0);
    check("run0_lat", waits, 0);
    check("run0_data", d, 0);

    s0 = n_wen; s1 = n_wen2; s2 = n_ren; s3 = n_ren2;
    send(2'd0, 32'h6, 32'h11111111);
    get_rsp(err, d, waits);
    check("mis_wr_err", err, 1);
    send(2'd2, 32'h12, 32'h1);
    get_rsp(err, d, waits);
    check("mis_rd_err", err, 1);
    check("mis_no_access", (n_wen - s0) + (n_wen2 - s1) + (n_ren - s2) + (n_ren2 - s3), 0);

    send(2'd2, 32'h10, 32'h1);
    waits = 0;
    while (!rsp_valid && waits < 50) begin @(negedge clk); waits++; end
    d0 = rsp_data; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d0 || cmd_ready) bad++;
    end
    check("bp_stable", bad, 0);
    check("bp_data", d0, 32'h1234);
    get_rsp(err, d, waits);
    check("bp_rdy_after", cmd_ready, 1);

    send(2'd3, 32'h0, 32'd100);
    repeat (19) @(negedge clk);
    check("rst_run_en", cpu_enable, 1);
    s0 = n_rv;
    arst_n = 0;
    @(negedge clk);
    check("rst_run_drop", {cpu_enable, rsp_valid, cmd_ready}, 0);
    repeat (3) @(negedge clk);
    arst_n = 1;
    repeat (2) @(negedge clk);
    check("rst_no_rsp", n_rv - s0, 0);
    check("rst_rdy", cmd_ready, 1);
    s0 = n_wen2;
    send(2'd1, 32'h20, 32'hA5A5A5A5);
    get_rsp(err, d, waits);
    check("post_rst_wen2", n_wen2 - s0, 1);
    check("post_rst_err", err, 0);
    send(2'd2, 32'h20, 32'h1);
    get_rsp(err, d, waits);
    check("post_rst_rd", d, 32'hA5A5A5A5);

`ifdef CPU_MEM_LOADER_VERIFY_EN
    corrupt = 1;
    send(2'd0, 32'h4, 32'h55);
    get_rsp(err, d, waits);
    corrupt = 0;
    check("vfy_err", err, 1);
    check("vfy_data", d, 32'h54);
`endif
    check("excl_viol", n_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
